// File: rtl/icache_ram_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ram_ctrl
//
// Controller and write-port arbiter for the instruction-cache data RAM
// (LINES lines of LW bits, one write port, one read port, 1-cycle read
// latency). After reset, and on every invalidate-all pulse, it sweeps zeros
// into every line. Outside a sweep it hands the RAM write port to cache-line
// fills from the bus interface. Reads are passed straight to the RAM, and the
// controller flags the returned data one cycle later.
//
// Optional feature macro: RAM_BYPASS_EN
//   defined   : a read and a fill to the same line in the same cycle return
//               the freshly written line (forwarded from a holding register)
//   undefined : rd_line is ram_o directly; a same-cycle read/write collision
//               returns undefined data and must be avoided by the fetch logic
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   inv_all    invalidate-all pulse (starts or restarts the clear sweep)
//   rdy        RAM contents valid; fills and reads accepted
//   fill_req   fill write request      fill_adr / fill_line : line address/data
//   fill_ack   fill accepted this cycle (combinational)
//   rd_en      read request            rd_adr : read line address
//   rd_vld     rd_line valid this cycle
//   rd_line    read data
//   ram_wr     RAM write enable        ram_wadr / ram_i : write address/data
//   ram_radr   RAM read address        ram_o : RAM read data (registered in RAM)
// -----------------------------------------------------------------------------
module icache_ram_ctrl #(
    parameter int LINES = 512,
    parameter int AW    = 9,
    parameter int LW    = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inv_all,
    output logic          rdy,
    input  logic          fill_req,
    input  logic [AW-1:0] fill_adr,
    input  logic [LW-1:0] fill_line,
    output logic          fill_ack,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_adr,
    output logic          rd_vld,
    output logic [LW-1:0] rd_line,
    output logic          ram_wr,
    output logic [AW-1:0] ram_wadr,
    output logic [AW-1:0] ram_radr,
    output logic [LW-1:0] ram_i,
    input  logic [LW-1:0] ram_o
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] sweep_cnt_q;
    logic [AW-1:0] sweep_cnt_d;
    logic          rd_vld_q;
    logic          rd_vld_d;
    logic          run_s;
    logic          clear_s;

    // Next-state logic: sweep progress and CLEAR/RUN transitions.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (inv_all) begin
                    // A new invalidate restarts the sweep; the current line
                    // is still written this cycle.
                    sweep_cnt_d = {AW{1'b0}};
                    state_d     = ST_CLEAR;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + AW'(1);
                    if (sweep_cnt_q == AW'(LINES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_RUN: begin
                if (inv_all) begin
                    state_d     = ST_CLEAR;
                    sweep_cnt_d = {AW{1'b0}};
                end else begin
                    state_d     = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                sweep_cnt_d = {AW{1'b0}};
            end
        endcase
        // A read is only honoured while the RAM contents are valid.
        rd_vld_d = rd_en & (state_q == ST_RUN);
    end

    // State, sweep counter and read-valid pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            sweep_cnt_q <= {AW{1'b0}};
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    // Write-port arbitration and status outputs; everything is held quiet
    // while reset is asserted.
    always_comb begin
        run_s    = (state_q == ST_RUN) & ~rst;
        clear_s  = (state_q == ST_CLEAR) & ~rst;
        rdy      = run_s;
        fill_ack = run_s & fill_req;
        ram_wr   = clear_s | (run_s & fill_req);
        ram_wadr = (state_q == ST_CLEAR) ? sweep_cnt_q : fill_adr;
        ram_i    = (state_q == ST_CLEAR) ? {LW{1'b0}} : fill_line;
        ram_radr = rd_adr;
        rd_vld   = rd_vld_q & ~rst;
    end

`ifdef RAM_BYPASS_EN
    logic          hit_q;
    logic [LW-1:0] fwd_q;

    // Capture a same-cycle read/write collision and the data being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
            fwd_q <= {LW{1'b0}};
        end else begin
            hit_q <= rd_en & ram_wr & (rd_adr == ram_wadr);
            fwd_q <= ram_i;
        end
    end

    // Return forwarded data on a collision, RAM data otherwise.
    always_comb begin
        rd_line = hit_q ? fwd_q : ram_o;
    end
`else
    // RAM data is returned as-is.
    always_comb begin
        rd_line = ram_o;
    end
`endif

endmodule

// File: tb/tb_icache_ram_ctrl.sv
// Self-checking bench for icache_ram_ctrl: a behavioural RAM, a line-level
// reference model and a scoreboard of expected RAM writes and read returns.
module tb_icache_ram_ctrl;
    localparam int LINES = 512;
    localparam int AW    = 9;
    localparam int LW    = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inv_all = 1'b0;
    logic          rdy;
    logic          fill_req = 1'b0;
    logic [AW-1:0] fill_adr = '0;
    logic [LW-1:0] fill_line = '0;
    logic          fill_ack;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_adr = '0;
    logic          rd_vld;
    logic [LW-1:0] rd_line;
    logic          ram_wr;
    logic [AW-1:0] ram_wadr;
    logic [AW-1:0] ram_radr;
    logic [LW-1:0] ram_i;
    logic [LW-1:0] ram_o = '0;

    icache_ram_ctrl #(.LINES(LINES), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .inv_all(inv_all), .rdy(rdy),
        .fill_req(fill_req), .fill_adr(fill_adr), .fill_line(fill_line),
        .fill_ack(fill_ack), .rd_en(rd_en), .rd_adr(rd_adr), .rd_vld(rd_vld),
        .rd_line(rd_line), .ram_wr(ram_wr), .ram_wadr(ram_wadr),
        .ram_radr(ram_radr), .ram_i(ram_i), .ram_o(ram_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int c; logic [AW-1:0] a; logic [LW-1:0] d; } wr_t;
    typedef struct { int c; logic [LW-1:0] d; bit k; } rd_t;
    wr_t wq[$];
    rd_t rdq[$];

    logic [LW-1:0] mem     [LINES];  // behavioural RAM contents
    logic [LW-1:0] ref_mem [LINES];  // what the cache should hold
    bit run_m = 1'b0;
    int swp_m = 0;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural RAM: registered read, collisions return garbage (no_change).
    always @(posedge clk) begin
        if (ram_wr) mem[ram_wadr] <= ram_i;
        if (ram_wr && ram_wadr == ram_radr) ram_o <= rand_line();
        else ram_o <= mem[ram_radr];
    end

    // Monitor: every RAM write and every read return is matched to the queues.
    always @(negedge clk) begin : mon
        wr_t we;
        rd_t re;
        if (ram_wr) begin
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                we = wq.pop_front();
                chk("wr_cycle", we.c, cyc);
                chk("wr_adr", ram_wadr, we.a);
                chk("wr_data", ram_i, we.d);
            end
        end
        while (wq.size() > 0 && wq[0].c <= cyc) begin
            chk("wr_missing", 0, 1);
            void'(wq.pop_front());
        end
        if (rd_vld) begin
            if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                re = rdq.pop_front();
                chk("rd_cycle", cyc, re.c);
                if (re.k) chk("rd_data", rd_line, re.d);
            end
        end
        while (rdq.size() > 0 && rdq[0].c <= cyc) begin
            chk("rd_missing", 0, 1);
            void'(rdq.pop_front());
        end
    end

    // One clock cycle of stimulus; the reference model predicts its effects.
    task automatic drive(input bit fr, input logic [AW-1:0] fa, input logic [LW-1:0] fl,
                         input bit re, input logic [AW-1:0] ra, input bit inv);
        bit was_run;
        bit exp_ack;
        bit k;
        logic [LW-1:0] d;
        fill_req = fr; fill_adr = fa; fill_line = fl;
        rd_en = re; rd_adr = ra; inv_all = inv;
        was_run = run_m;
        if (!run_m) begin
            exp_ack = 1'b0;
            wq.push_back('{cyc, AW'(swp_m), '0});
            ref_mem[swp_m] = '0;
            if (inv) swp_m = 0;
            else swp_m++;
            if (swp_m == LINES) run_m = 1'b1;
        end else begin
            exp_ack = fr;
            if (re) begin
                d = ref_mem[ra];
                k = 1'b1;
                if (fr && fa == ra) begin
`ifdef RAM_BYPASS_EN
                    d = fl;
`else
                    k = 1'b0;
`endif
                end
                rdq.push_back('{cyc + 1, d, k});
            end
            if (fr) begin
                wq.push_back('{cyc, fa, fl});
                ref_mem[fa] = fl;
            end
            if (inv) begin
                run_m = 1'b0;
                swp_m = 0;
            end
        end
        @(negedge clk);
        chk("rdy", rdy, was_run);
        chk("fill_ack", fill_ack, exp_ack);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; fill_req = 1'b1; rd_en = 1'b1; inv_all = 1'b0;
        rdq.delete();
        run_m = 1'b0; swp_m = 0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_rdy", rdy, 0);
            chk("rst_ram_wr", ram_wr, 0);
            chk("rst_fill_ack", fill_ack, 0);
            chk("rst_rd_vld", rd_vld, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Sweep with random fills and reads offered; returns cycles until rdy.
    task automatic sweep_until_run(output int n, input int inv_at);
        bit done;
        done = 1'b0;
        n = 0;
        while (!run_m && n < 2000) begin
            bit inv;
            inv = (!done && inv_at >= 0 && swp_m == inv_at);
            if (inv) done = 1'b1;
            drive(1'b1, AW'($urandom), rand_line(), 1'($urandom), AW'($urandom), inv);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [LW-1:0] pat;
        logic [LW-1:0] uv [4];
        for (int i = 0; i < LINES; i++) begin
            mem[i] = rand_line();
            ref_mem[i] = rand_line();
        end

        // Reset sweep
        do_reset(2);
        sweep_until_run(n, -1);
        chk("sweep_len", n, 512);
        idle();

        // Fill then read back, neighbour still cleared
        pat = {64{8'hA5}};
        drive(1'b1, 9'h1A5, pat, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 9'h1A5, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 9'h1A4, 1'b0);
        idle();

        // Back-to-back reads of four unique lines
        for (int i = 0; i < 4; i++) begin
            uv[i] = rand_line();
            drive(1'b1, AW'(i), uv[i], 1'b0, '0, 1'b0);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
        idle();

        // Same-cycle fill and read of line 7
        drive(1'b1, 9'd7, {64{8'h5A}}, 1'b1, 9'd7, 1'b0);
        idle();

        // Random traffic concentrated on a few lines
        repeat (300) drive(1'($urandom), AW'($urandom_range(0, 15)), rand_line(),
                           1'($urandom), AW'($urandom_range(0, 15)), 1'b0);

        // inv_all with fills held asserted
        repeat (3) drive(1'b1, AW'($urandom), rand_line(), 1'b0, '0, 1'b0);
        drive(1'b1, 9'h055, rand_line(), 1'b0, '0, 1'b1);
        sweep_until_run(n, -1);
        chk("inv_sweep_len", n, 512);
        repeat (3) drive(1'b1, AW'($urandom), rand_line(), 1'b1 , AW'($urandom), 1'b0);

        // Second inv_all at count 100 extends the sweep
        drive(1'b1, 9'h0AA, rand_line(), 1'b0, '0, 1'b1);
        sweep_until_run(n, 100);
        chk("ext_sweep_len", n, 613);
        repeat (20) drive(1'($urandom), AW'($urandom), rand_line(), 1'($urandom), AW'($urandom), 1'b0);

        // Read right before reset: return must be dropped
        drive(1'b0, '0, '0, 1'b1, 9'h003, 1'b0);
        do_reset(1);
        idle();
        chk("drop_rd_vld", rd_vld, 0);

        // Reset mid-sweep at count 300
        while (swp_m < 300) idle();
        do_reset(2);
        sweep_until_run(n, -1);
        chk("mid_rst_sweep_len", n, 512);
        for (int i = 0; i < 8; i++) drive(1'b0, '0, '0, 1'b1, AW'($urandom_range(0, 15)), 1'b0);
        repeat (3) idle();

        chk("rdq_empty", rdq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
